// File: rtl/lfsr_pkg.sv
// ----------------------------------------------------------------------------
// lfsr_pkg
//   Definitions shared by the 32-bit LFSR generator and its receive-side
//   checker. Polynomial x^32 + x^22 + x^2 + x + 1, Fibonacci form.
//
//   Contents:
//     LFSR_W       word width (32)
//     LFSR_TAPS    tap mask (bits 31, 21, 1, 0)
//     lfsr_next()  one-step advance of the register
//     chk_state_t  checker FSM states {HUNT, VERIFY, LOCKED}
// ----------------------------------------------------------------------------
package lfsr_pkg;

   localparam int LFSR_W = 32;

   // Bit i set means s[i] feeds the XOR. x^22, x^2, x^1 and x^0 terms map
   // to register bits 21, 1, 0 plus the shifted-out bit 31.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } chk_state_t;

endpackage

// File: rtl/lfsr_popcount32.sv
// ----------------------------------------------------------------------------
// lfsr_popcount32
//   Combinational population count of a 32-bit word.
//
//   Ports:
//     din    in  32  word to count
//     count  out 6   number of set bits in din (0..32)
// ----------------------------------------------------------------------------
module lfsr_popcount32 (
   input  logic [31:0] din,
   output logic [5:0]  count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < 32; i++) begin
         count = count + {5'b0, din[i]};
      end
   end

endmodule

// File: rtl/lfsr_checker.sv
// ----------------------------------------------------------------------------
// lfsr_checker
//   Receive-side checker for the 32-bit lfsr stream. Seeds its predictor from
//   received data (HUNT), confirms LOCK_CNT consecutive correct predictions
//   (VERIFY), then flywheels its own prediction (LOCKED) and counts
//   mismatches. LOSS_CNT consecutive locked mismatches drop back to HUNT.
//
//   Optional feature macro: LFSR_CHK_BITERR_EN
//     defined   -> each locked mismatch adds popcount(din ^ expected)
//     undefined -> each locked mismatch adds 1 (word-error count)
//
//   Parameters:
//     LOCK_CNT  correct predictions needed to lock (1..255)
//     LOSS_CNT  consecutive locked mismatches that drop lock (1..255)
//     CNT_W     width of err_count
//
//   Ports:
//     clk        in  1      rising-edge clock
//     rst        in  1      synchronous, active-low reset
//     din        in  32     received LFSR word
//     din_valid  in  1      din is sampled only when high
//     clr        in  1      synchronous clear of err_count
//     locked     out 1      high in LOCKED
//     err_pulse  out 1      one-cycle pulse on a locked-state mismatch
//     err_count  out CNT_W  saturating error count
//     expected   out 32     prediction of the next din
//     dbg_state  out 2      current FSM state (chk_state_t encoding)
//
//   Handshake: a word is consumed on every rising edge where din_valid is
//   high; there is no back-pressure. Cycles with din_valid low leave all
//   state untouched and keep err_pulse low.
// ----------------------------------------------------------------------------
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned LOSS_CNT = 3,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       din,
   input  logic              din_valid,
   input  logic              clr,
   output logic              locked,
   output logic              err_pulse,
   output logic [CNT_W-1:0]  err_count,
   output logic [31:0]       expected,
   output logic [1:0]        dbg_state
);

   localparam logic [7:0] LOCK_TGT = LOCK_CNT[7:0];
   localparam logic [7:0] LOSS_TGT = LOSS_CNT[7:0];

   chk_state_t state;
   logic [7:0] run;
   logic [7:0] miss;

   logic       match;
   logic       lock_err;
   logic [5:0] err_inc;
   logic [7:0] run_inc;
   logic [7:0] miss_inc;

   logic [CNT_W-1:0] cnt_base;
   logic [CNT_W+5:0] cnt_sum;
   logic [CNT_W-1:0] cnt_sat;

   assign match    = (din == expected);
   assign lock_err = din_valid && (state == LOCKED) && !match;
   assign run_inc  = run + 8'd1;
   assign miss_inc = miss + 8'd1;
   assign dbg_state = state;

`ifdef LFSR_CHK_BITERR_EN
   logic [31:0] diff;
   assign diff = din ^ expected;

   lfsr_popcount32 u_popcount (
      .din   (diff),
      .count (err_inc)
   );
`else
   assign err_inc = 6'd1;
`endif

   // Clear is applied before the increment, so clr with an error in the
   // same cycle leaves exactly the increment amount. The sum is six bits
   // wider than the counter so any carry out means saturate.
   assign cnt_base = clr ? '0 : err_count;
   assign cnt_sum  = {6'b0, cnt_base} + {{CNT_W{1'b0}}, err_inc};
   assign cnt_sat  = (|cnt_sum[CNT_W+5:CNT_W]) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= HUNT;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_count <= '0;
         expected  <= '0;
         run       <= '0;
         miss      <= '0;
      end else begin
         err_pulse <= lock_err;

         // Error statistics are independent of the FSM state.
         if (lock_err) begin
            err_count <= cnt_sat;
         end else if (clr) begin
            err_count <= '0;
         end

         if (din_valid) begin
            case (state)
               HUNT: begin
                  // An all-zero word is the LFSR lock-up value and can never
                  // seed a valid sequence.
                  if (din != '0) begin
                     expected <= lfsr_next(din);
                     run      <= '0;
                     state    <= VERIFY;
                  end
               end

               VERIFY: begin
                  if (match) begin
                     expected <= lfsr_next(expected);
                     run      <= run_inc;
                     if (run_inc == LOCK_TGT) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                        miss   <= '0;
                     end
                  end else if (din == '0) begin
                     run   <= '0;
                     state <= HUNT;
                  end else begin
                     expected <= lfsr_next(din);
                     run      <= '0;
                  end
               end

               LOCKED: begin
                  // Flywheel: never re-seed from din while locked.
                  expected <= lfsr_next(expected);
                  if (match) begin
                     miss <= '0;
                  end else begin
                     miss <= miss_inc;
                     if (miss_inc == LOSS_TGT) begin
                        state  <= HUNT;
                        locked <= 1'b0;
                     end
                  end
               end

               default: begin
                  state  <= HUNT;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lfsr_checker.sv
// ----------------------------------------------------------------------------
// tb_lfsr_checker
//   Directed bench for lfsr_checker (LOCK_CNT=4, LOSS_CNT=3, CNT_W=4).
//   Words are driven on the falling edge and outputs are sampled 1 ns after
//   the rising edge that consumed them.
// ----------------------------------------------------------------------------
module tb_lfsr_checker;

   localparam int CNT_W = 4;
   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_VERIFY = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   logic             clk;
   logic             rst;
   logic [31:0]      din;
   logic             din_valid;
   logic             clr;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;
   logic [31:0]      expected;
   logic [1:0]       dbg_state;

   int vec_cnt;
   int mis_cnt;

   logic [31:0] gen_s;
   logic [31:0] hold_exp;
   logic [31:0] big_err;

   lfsr_checker #(
      .LOCK_CNT (4),
      .LOSS_CNT (3),
      .CNT_W    (CNT_W)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .clr       (clr),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .expected  (expected),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference generator: x^32+x^22+x^2+x+1, feedback into bit 0.
   function automatic logic [31:0] gen_next(input logic [31:0] s);
      logic fb;
      fb = s[31] ^ s[21] ^ s[1] ^ s[0];
      return {s[30:0], fb};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         mis_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic send(input logic [31:0] w, input logic v, input logic c);
      @(negedge clk);
      din       = w;
      din_valid = v;
      clr       = c;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      clr       = 1'b0;
   endtask

   task automatic send_good();
      send(gen_s, 1'b1, 1'b0);
      gen_s = gen_next(gen_s);
   endtask

   task automatic send_bad(input logic [31:0] mask, input logic c);
      send(gen_s ^ mask, 1'b1, c);
      gen_s = gen_next(gen_s);
   endtask

   initial begin
      vec_cnt   = 0;
      mis_cnt   = 0;
      rst       = 1'b0;
      din       = 32'h0;
      din_valid = 1'b0;
      clr       = 1'b0;
      big_err   = 32'hFFFF_0000;

      // Reset
      repeat (2) @(posedge clk);
      #1;
      check("rst_locked",    {31'b0, locked},    32'h0);
      check("rst_err_pulse", {31'b0, err_pulse}, 32'h0);
      check("rst_err_count", {28'b0, err_count}, 32'h0);
      check("rst_expected",  expected,           32'h0);
      check("rst_state",     {30'b0, dbg_state}, {30'b0, ST_HUNT});
      @(negedge clk);
      rst = 1'b1;

      // Zero words in HUNT are ignored
      send(32'h0, 1'b1, 1'b0);
      send(32'h0, 1'b1, 1'b0);
      check("hunt_zero_state", {30'b0, dbg_state}, {30'b0, ST_HUNT});
      check("hunt_zero_exp",   expected,           32'h0);

      // Seed 1 sequence: 1, 3, 6, D, 1B -> predictions 3, 6, D, 1B, 36
      gen_s = 32'h1;
      send_good();
      check("seed_exp1",  expected,           32'h3);
      check("seed_state", {30'b0, dbg_state}, {30'b0, ST_VERIFY});
      send_good();
      check("seed_exp2",  expected,           32'h6);
      check("verify_state", {30'b0, dbg_state}, {30'b0, ST_VERIFY});
      send_good();
      check("seed_exp3",  expected,           32'hD);
      send_good();
      check("seed_exp4",  expected,           32'h1B);
      check("not_yet_locked", {31'b0, locked}, 32'h0);
      send_good();
      check("seed_exp5",  expected,           32'h36);
      check("locked_5th", {31'b0, locked},    32'h1);
      check("locked_state", {30'b0, dbg_state}, {30'b0, ST_LOCKED});

      // Run out to 100 words with no errors
      for (int i = 5; i < 100; i++) send_good();
      check("run100_errs",   {28'b0, err_count}, 32'h0);
      check("run100_locked", {31'b0, locked},    32'h1);
      check("run100_exp",    expected,           gen_s);

      // din_valid low for 10 cycles freezes state
      hold_exp = expected;
      for (int i = 0; i < 10; i++) send(32'hDEAD_BEEF, 1'b0, 1'b0);
      check("idle_exp",    expected,           hold_exp);
      check("idle_locked", {31'b0, locked},    32'h1);
      check("idle_pulse",  {31'b0, err_pulse}, 32'h0);
      for (int i = 0; i < 5; i++) send_good();
      check("resume_errs", {28'b0, err_count}, 32'h0);

      // Single bit-0 flip while locked
      send_bad(32'h1, 1'b0);
      check("flip_pulse",  {31'b0, err_pulse}, 32'h1);
      check("flip_count",  {28'b0, err_count}, 32'h1);
      check("flip_locked", {31'b0, locked},    32'h1);
      send_good();
      check("flip_pulse_end", {31'b0, err_pulse}, 32'h0);
      // Two misses, a good word, two more misses: the good word must have
      // reset the miss run, so lock holds.
      send_bad(32'h1, 1'b0);
      send_bad(32'h1, 1'b0);
      send_good();
      send_bad(32'h1, 1'b0);
      send_bad(32'h1, 1'b0);
      check("miss_reset_locked", {31'b0, locked},    32'h1);
      check("miss_reset_count",  {28'b0, err_count}, 32'h5);
      send_good();

      // Three consecutive 0xFFFF0000 corruptions drop lock
      send(32'h0, 1'b0, 1'b1);
      check("clr_alone", {28'b0, err_count}, 32'h0);
      send_bad(big_err, 1'b0);
      send_bad(big_err, 1'b0);
      check("loss_2nd_locked", {31'b0, locked}, 32'h1);
      send_bad(big_err, 1'b0);
      check("loss_3rd_locked", {31'b0, locked},    32'h0);
      check("loss_state",      {30'b0, dbg_state}, {30'b0, ST_HUNT});
`ifdef LFSR_CHK_BITERR_EN
      // 48 bit errors saturate the 4-bit counter
      check("loss_count", {28'b0, err_count}, 32'hF);
`else
      check("loss_count", {28'b0, err_count}, 32'h3);
`endif

      // Relock, then saturate the counter
      for (int i = 0; i < 5; i++) send_good();
      check("relock", {31'b0, locked}, 32'h1);
      send(32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         send_bad(32'h1, 1'b0);
         send_bad(32'h1, 1'b0);
         send_good();
      end
      check("sat_count",  {28'b0, err_count}, 32'hF);
      check("sat_locked", {31'b0, locked},    32'h1);
      send_bad(32'h1, 1'b0);
      check("sat_hold", {28'b0, err_count}, 32'hF);
      send_good();
      send_bad(32'h1, 1'b1);
      check("clr_with_err", {28'b0, err_count}, 32'h1);
      check("clr_with_err_pulse", {31'b0, err_pulse}, 32'h1);
      send(gen_s, 1'b1, 1'b1);
      gen_s = gen_next(gen_s);
      check("clr_good", {28'b0, err_count}, 32'h0);

      // Reset while locked overrides clr and data
      send_bad(32'h1, 1'b0);
      @(negedge clk);
      rst       = 1'b0;
      din       = gen_s ^ 32'h1;
      din_valid = 1'b1;
      clr       = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_locked",   {31'b0, locked},    32'h0);
      check("mid_rst_count",    {28'b0, err_count}, 32'h0);
      check("mid_rst_expected", expected,           32'h0);
      check("mid_rst_pulse",    {31'b0, err_pulse}, 32'h0);
      check("mid_rst_state",    {30'b0, dbg_state}, {30'b0, ST_HUNT});
      @(negedge clk);
      rst       = 1'b1;
      din_valid = 1'b0;
      clr       = 1'b0;

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
      $finish;
   end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the 32-bit `lfsr` generator. It accepts one 32-bit word per valid cycle from the `lfsr` output and self-synchronises to the sequence by seeding its predictor from received data. Once synchronised, it flywheels its own prediction and reports lock status and mismatch statistics. It sits at the far end of any link or loopback that carries the `lfsr` `q` stream, so sequence integrity can be checked in hardware rather than only against `testvectors.txt`.

## Interface
Parameters:
- `LOCK_CNT`, 4: consecutive correct predictions needed to declare lock (1..255).
- `LOSS_CNT`, 3: consecutive mismatches while locked that drop lock (1..255).
- `CNT_W`, 16: width of the error counter.

Ports:
- `clk` in 1: single clock; everything is on its rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `din` in 32: received LFSR word.
- `din_valid` in 1: `din` is sampled only when this is high.
- `clr` in 1: synchronous clear of `err_count`.
- `locked` out 1: high in LOCKED state.
- `err_pulse` out 1: one-cycle pulse when a locked-state mismatch is sampled.
- `err_count` out CNT_W: saturating error count.
- `expected` out 32: current prediction of the next `din`.

## Operation
- Polynomial x^32+x^22+x^2+x+1, same as `lfsr`, Fibonacci form. `next(s) = {s[30:0], s[31]^s[21]^s[1]^s[0]}`.
- States:
  - HUNT: a valid nonzero `din` loads `expected <= next(din)`, clears `run`, and moves to VERIFY. A valid `din == 0` (lock-up word) is ignored and the block stays in HUNT.
  - VERIFY: on valid with `din == expected`, `run++` and `expected <= next(expected)`. When `run` reaches `LOCK_CNT`, go to LOCKED and clear `miss`. On valid with `din != expected`, re-seed with `expected <= next(din)`, set `run = 0`, and stay in VERIFY. If that `din` is 0, go to HUNT instead. No errors are counted in VERIFY.
  - LOCKED: on every valid, `expected <= next(expected)` (flywheel; it is never re-seeded from `din`).
    - Match: `miss = 0`.
    - Mismatch: `err_pulse = 1`, `err_count` increments, `miss++`. When `miss` reaches `LOSS_CNT`, go to HUNT.
- Cycles with `din_valid` low change no state; `err_pulse` is 0 in those cycles.
- `err_count` saturates at all-ones; it never wraps.
- `clr` together with an error in the same cycle: `err_count` becomes the increment amount (the clear applies first, then the error adds). `clr` alone sets `err_count` to 0.
- `err_count` and `clr` are independent of state; leaving LOCKED does not clear the count.

## Timing
- Reset values: state HUNT, `locked = 0`, `err_pulse = 0`, `err_count = 0`, `expected = 0`, `run = 0`, `miss = 0`.
- All outputs are registered. The effect of a word sampled at edge k is visible after edge k, i.e. usable at edge k+1.
- Minimum time to lock: 1 + `LOCK_CNT` valid words after reset.
- Loss of lock: `locked` falls after the edge that samples the `LOSS_CNT`-th consecutive mismatch.
- Reset asserted in any state returns to reset values at the next edge. This overrides `clr` and all data.

## Configuration
- `LFSR_CHK_BITERR_EN` defined: each locked mismatch adds `popcount(din ^ expected)` (1..32) to `err_count`, still saturating.
- Not defined: each locked mismatch adds exactly 1 (word-error count).
- Lock and loss decisions are identical in both builds.

## Structure
- Shared package `lfsr_pkg`:
  - `LFSR_W = 32`
  - tap constant
  - function `lfsr_next`, also used by `lfsr`
  - state enum `chk_state_t` {HUNT, VERIFY, LOCKED}
- Sub-module `lfsr_popcount32`: combinational popcount producing a 6-bit result. It is instantiated only under `LFSR_CHK_BITERR_EN`.

## Test plan
- Reset, then feed `lfsr` output for seed 1 (0x1, 0x3, 0x6, 0xD, ...) -> `locked` rises after the 5th valid word; `err_count` stays 0 over 100 words.
- Once locked, flip bit 0 of one word -> `err_pulse` for one cycle and `err_count = 1` (1 in BITERR build). `locked` stays high and the next correct word clears `miss`.
- Once locked, corrupt 3 consecutive words with 0xFFFF0000 -> `locked` falls after the 3rd. `err_count = 3`, or 48 in the BITERR build.
- Feed 0x0 words in HUNT -> state stays HUNT, `expected = 0`. Then feed 0x1, 0x3 -> `expected = 0x6`, state VERIFY.
- Hold `din_valid` low for 10 cycles mid-lock -> no state change. Resume the sequence -> no errors.
- Preload `err_count` to all-ones (CNT_W=4 build, 15 errors), inject a further error -> `err_count` stays 15. Assert `clr` together with an error -> `err_count = 1`.
